// File: rtl/gray_mon_pkg.sv
// Shared types for the Gray-code step monitor: FSM states and step classes.
package gray_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StFault
    } mon_state_e;

    typedef enum logic [1:0] {
        StepHold,
        StepInc,
        StepDec,
        StepJump
    } step_cls_e;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_step_monitor.sv
// Checks that a Gray-coded counter advances by single +1 steps and counts wraps and faults.
// Define GRAY_MON_DEC_EN to accept -1 steps as legal (wrap_cnt then counts down on 0 -> all-ones).
module gray_step_monitor
    import gray_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             sample_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_ok,
    output logic             step_err,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

`ifdef GRAY_MON_DEC_EN
    localparam bit DecEn = 1'b1;
`else
    localparam bit DecEn = 1'b0;
`endif

    mon_state_e       state_q;
    logic [WIDTH-1:0] bin_new;
    step_cls_e        step_cls;

    gray_to_bin #(
        .WIDTH(WIDTH)
    ) u_gray_to_bin (
        .gray(gray_in),
        .bin (bin_new)
    );

    // bin_out doubles as the stored reference value; a -1 step is a jump unless enabled.
    always_comb begin
        step_cls = StepJump;
        if (bin_new == bin_out) begin
            step_cls = StepHold;
        end else if (bin_new == bin_out + WIDTH'(1)) begin
            step_cls = StepInc;
        end else if (bin_new == bin_out - WIDTH'(1)) begin
            step_cls = DecEn ? StepDec : StepJump;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            bin_out  <= '0;
            step_ok  <= 1'b0;
            step_err <= 1'b0;
            wrap_cnt <= '0;
            err_cnt  <= '0;
            fault    <= 1'b0;
        end else begin
            step_ok  <= 1'b0;
            step_err <= 1'b0;
            if (clr_err) begin
                // Any sample arriving with the clear is dropped.
                state_q <= StIdle;
                fault   <= 1'b0;
                err_cnt <= '0;
            end else if (sample_en) begin
                bin_out <= bin_new;
                case (state_q)
                    StIdle: begin
                        state_q <= StTrack;
                    end
                    StTrack: begin
                        case (step_cls)
                            StepInc: begin
                                step_ok <= 1'b1;
                                if (&bin_out) begin
                                    wrap_cnt <= wrap_cnt + CNT_W'(1);
                                end
                            end
                            StepDec: begin
                                step_ok <= 1'b1;
                                if (bin_out == '0) begin
                                    wrap_cnt <= wrap_cnt - CNT_W'(1);
                                end
                            end
                            StepJump: begin
                                step_err <= 1'b1;
                                if (!(&err_cnt)) begin
                                    err_cnt <= err_cnt + CNT_W'(1);
                                end
                                state_q <= StFault;
                                fault   <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Scoreboard bench for gray_step_monitor: a behavioural model queues expected outputs per cycle.
module tb_gray_step_monitor;

`ifdef GRAY_MON_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] bin;
        logic       ok;
        logic       err;
        logic       flt;
        logic [7:0] wrap;
        logic [7:0] errc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] gray_in = '0;
    logic       sample_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] bin_out;
    logic       step_ok;
    logic       step_err;
    logic [7:0] wrap_cnt;
    logic [7:0] err_cnt;
    logic       fault;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    // Model state: 0 idle, 1 track, 2 fault.
    int         m_st = 0;
    logic [3:0] m_bin = '0;
    logic [7:0] m_wrap = '0;
    logic [7:0] m_err = '0;

    gray_step_monitor #(
        .WIDTH(4),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .gray_in  (gray_in),
        .sample_en(sample_en),
        .clr_err  (clr_err),
        .bin_out  (bin_out),
        .step_ok  (step_ok),
        .step_err (step_err),
        .wrap_cnt (wrap_cnt),
        .err_cnt  (err_cnt),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("bin=%0d ok=%b err=%b fault=%b wrap=%0d errc=%0d",
                         v.bin, v.ok, v.err, v.flt, v.wrap, v.errc);
    endfunction

    function automatic exp_t observe();
        return {bin_out, step_ok, step_err, fault, wrap_cnt, err_cnt};
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_bin = '0;
        m_wrap = '0;
        m_err = '0;
        sb.delete();
    endtask

    task automatic model_push(input logic [3:0] g, input logic en, input logic clr);
        exp_t e;
        logic [3:0] nb;
        nb = g2b(g);
        e = '0;
        if (clr) begin
            m_st = 0;
            m_err = '0;
        end else if (en) begin
            if (m_st == 1) begin
                if (nb == m_bin + 4'd1) begin
                    e.ok = 1'b1;
                    if (m_bin == 4'hf) m_wrap++;
                end else if (DEC_EN && nb == m_bin - 4'd1) begin
                    e.ok = 1'b1;
                    if (m_bin == 4'h0) m_wrap--;
                end else if (nb != m_bin) begin
                    e.err = 1'b1;
                    if (m_err != 8'hff) m_err++;
                    m_st = 2;
                end
            end else if (m_st == 0) begin
                m_st = 1;
            end
            m_bin = nb;
        end
        e.bin = m_bin;
        e.flt = (m_st == 2);
        e.wrap = m_wrap;
        e.errc = m_err;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, queue its expectation, and land 1 ns after the edge.
    task automatic drive(input logic [3:0] g, input logic en, input logic clr);
        gray_in = g;
        sample_en = en;
        clr_err = clr;
        model_push(g, en, clr);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        exp_t o;
        repeat (2) @(posedge clk);
        #1;
        o = observe();
        total++;
        if (o !== exp_t'(0)) begin
            bad++;
            $display("FAIL reset_state: got %s want all zero", fmt(o));
        end
        reset = 1'b0;
        model_reset();
        drive(4'b0110, 1'b0, 1'b0);
        o = observe();
        total++;
        if (o !== sb.pop_front()) begin
            bad++;
            $display("FAIL reset_idle_hold: got %s", fmt(o));
        end
    endtask

    task automatic test_count();
        logic [3:0] g[7] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111, 4'b0011, 4'b0011, 4'b0010};
        logic       en[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] want_bin[7] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
        logic       want_ok[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e, o;
        for (int i = 0; i < 7; i++) begin
            drive(g[i], en[i], 1'b0);
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL count[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            total++;
            if (bin_out !== want_bin[i] || step_ok !== want_ok[i] || step_err !== 1'b0) begin
                bad++;
                $display("FAIL count_fixed[%0d]: got bin=%0d ok=%b err=%b want bin=%0d ok=%b err=0",
                         i, bin_out, step_ok, step_err, want_bin[i], want_ok[i]);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e, o;
        logic [3:0] b;
        for (int i = 4; i <= 16; i++) begin
            b = 4'(i);
            drive(b2g(b), 1'b1, 1'b0);
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL wrap[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
        total++;
        if (bin_out !== 4'd0 || step_ok !== 1'b1 || wrap_cnt !== 8'd1) begin
            bad++;
            $display("FAIL wrap_fixed: got bin=%0d ok=%b wrap=%0d want bin=0 ok=1 wrap=1",
                     bin_out, step_ok, wrap_cnt);
        end
    endtask

    task automatic test_jump();
        logic [3:0] g[4] = '{4'b0001, 4'b0011, 4'b1101, 4'b1100};
        exp_t e, o;
        for (int i = 0; i < 4; i++) begin
            drive(g[i], 1'b1, 1'b0);
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL jump[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 2) begin
                total++;
                if (step_err !== 1'b1 || fault !== 1'b1 || err_cnt !== 8'd1 || bin_out !== 4'd9) begin
                    bad++;
                    $display("FAIL jump_fixed: got err=%b fault=%b errc=%0d bin=%0d want 1 1 1 9",
                             step_err, fault, err_cnt, bin_out);
                end
            end
        end
        total++;
        if (step_ok !== 1'b0 || step_err !== 1'b0 || bin_out !== 4'd8) begin
            bad++;
            $display("FAIL fault_quiet: got ok=%b err=%b bin=%0d want ok=0 err=0 bin=8",
                     step_ok, step_err, bin_out);
        end
    endtask

    task automatic test_clr();
        logic [3:0] g[3] = '{4'b0111, 4'b0101, 4'b0100};
        logic       clr[3] = '{1'b1, 1'b0, 1'b0};
        exp_t e, o;
        for (int i = 0; i < 3; i++) begin
            drive(g[i], 1'b1, clr[i]);
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL clr[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 0) begin
                total++;
                if (fault !== 1'b0 || err_cnt !== 8'd0 || bin_out !== 4'd8 || wrap_cnt !== 8'd1) begin
                    bad++;
                    $display("FAIL clr_fixed: got fault=%b errc=%0d bin=%0d wrap=%0d want 0 0 8 1",
                             fault, err_cnt, bin_out, wrap_cnt);
                end
            end
            if (i == 1) begin
                total++;
                if (step_ok !== 1'b0 || step_err !== 1'b0 || bin_out !== 4'd6) begin
                    bad++;
                    $display("FAIL clr_reload: got ok=%b err=%b bin=%0d want ok=0 err=0 bin=6",
                             step_ok, step_err, bin_out);
                end
            end
        end
    endtask

    task automatic test_dec();
        logic [3:0] g[4] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000};
        logic       clr[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_t e, o;
        for (int i = 0; i < 4; i++) begin
            drive(g[i], 1'b1, clr[i]);
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL dec[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 2) begin
                total++;
                if (DEC_EN ? (step_ok !== 1'b1 || step_err !== 1'b0 || fault !== 1'b0)
                           : (step_ok !== 1'b0 || step_err !== 1'b1 || fault !== 1'b1)) begin
                    bad++;
                    $display("FAIL dec_fixed: got ok=%b err=%b fault=%b with dec_en=%b",
                             step_ok, step_err, fault, DEC_EN);
                end
            end
        end
        total++;
        if (wrap_cnt !== (DEC_EN ? 8'd0 : 8'd1)) begin
            bad++;
            $display("FAIL dec_wrap: got wrap=%0d want %0d", wrap_cnt, DEC_EN ? 0 : 1);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e, o;
        for (int i = 0; i <= 7; i++) begin
            drive(b2g(4'(i)), 1'b1, (i == 0));
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_count[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
        #2;
        reset = 1'b1;
        #1;
        o = observe();
        total++;
        if (o !== exp_t'(0)) begin
            bad++;
            $display("FAIL midrst_async: got %s want all zero", fmt(o));
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4'b0110, 1'b1, 1'b0);
        e = sb.pop_front();
        o = observe();
        total++;
        if (o !== e || step_ok !== 1'b0 || bin_out !== 4'd4) begin
            bad++;
            $display("FAIL midrst_first: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        logic [3:0] cur;
        int r;
        cur = 4'd4;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99);
            if (r < 60) cur = cur + 4'd1;
            else if (r < 72) cur = cur - 4'd1;
            else if (r < 84) cur = cur;
            else cur = 4'($urandom_range(15));
            drive(b2g(cur), ($urandom_range(9) < 8), ($urandom_range(19) == 0));
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_jump();
        test_clr();
        test_dec();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_step_monitor.md
GRAY_STEP_MONITOR -- requirements
Module: gray_step_monitor

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the Gray code width consumed from the upstream counter.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of wrap_cnt and err_cnt.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 gray_in  input  WIDTH  SHALL carry the Gray code sample from the upstream counter.
REQ-006 sample_en  input  1  SHALL qualify gray_in; unqualified cycles are ignored.
REQ-007 clr_err  input  1  SHALL clear FAULT state and err_cnt.
REQ-008 bin_out  output  WIDTH  SHALL be the registered binary decode of the last qualified sample.
REQ-009 step_ok  output  1  SHALL be a one-cycle pulse marking a legal +1 step.
REQ-010 step_err  output  1  SHALL be a one-cycle pulse marking an illegal step.
REQ-011 wrap_cnt  output  CNT_W  SHALL count legal steps from all-ones binary to zero, modulo 2^CNT_W.
REQ-012 err_cnt  output  CNT_W  SHALL count illegal steps, saturating at all-ones.
REQ-013 fault  output  1  SHALL be high while the FSM is in FAULT.

Function
REQ-014 The FSM SHALL have states IDLE, TRACK and FAULT.
REQ-015 In IDLE, a qualified sample SHALL load the reference and bin_out, move to TRACK, and raise no pulse.
REQ-016 In TRACK and FAULT, each qualified sample SHALL be classified against the stored previous binary value:
- HOLD: equal values.
- INC: new value = previous + 1 mod 2^WIDTH.
- DEC: new value = previous - 1 mod 2^WIDTH.
- JUMP: any other value.
REQ-017 In TRACK, INC SHALL pulse step_ok; HOLD SHALL raise no pulse.
REQ-018 In TRACK, JUMP SHALL pulse step_err, increment err_cnt, and move to FAULT.
REQ-019 INC from all-ones binary to zero SHALL increment wrap_cnt in the same cycle as step_ok.
REQ-020 In FAULT, samples SHALL still update bin_out and the reference, and SHALL raise no pulses or counter changes.
REQ-021 clr_err SHALL move the FSM to IDLE and zero err_cnt; wrap_cnt SHALL be unaffected.
REQ-022 clr_err SHALL take priority over a qualified sample in the same cycle; that sample SHALL be dropped.
REQ-023 All outputs SHALL be registered, with one-cycle latency from a qualified sample to bin_out and the pulses.
REQ-024 The reference and bin_out SHALL hold when sample_en is low.

Reset
REQ-025 Reset SHALL force IDLE, bin_out=0, step_ok=0, step_err=0, wrap_cnt=0, err_cnt=0 and fault=0 immediately, including mid-sequence.
REQ-026 The first qualified sample after reset release SHALL be treated as an IDLE load.

Configuration
REQ-027 With GRAY_MON_DEC_EN defined, DEC in TRACK SHALL pulse step_ok and SHALL be treated as legal, and a DEC step from zero to all-ones SHALL decrement wrap_cnt.
REQ-028 Without GRAY_MON_DEC_EN, DEC SHALL be handled exactly as JUMP.

Structure
REQ-029 Package gray_mon_pkg SHALL hold the FSM state enum and the step-class enum (HOLD/INC/DEC/JUMP).
REQ-030 The Gray-to-binary decode SHALL be a combinational sub-module named gray_to_bin, parameterised by WIDTH.

Verification
REQ-031 Reset, then qualified gray_in 0000,0001,0011,0010 -> bin_out 0,1,2,3; step_ok high on the last three samples; step_err never high.
REQ-032 Count to gray 1000 (binary 15), then sample 0000 -> step_ok pulse, wrap_cnt 0->1.
REQ-033 From gray 0011, sample 1101 (binary 9, an upstream load) -> step_err pulse, fault=1, err_cnt=1; the next sample 1100 raises no step_ok.
REQ-034 In FAULT, clr_err together with a qualified sample -> fault=0, err_cnt=0, FSM in IDLE, sample dropped; the next sample reloads without a pulse.
REQ-035 Assert reset mid-count at binary 7 -> all outputs zero asynchronously; after release, the first sample raises no pulse.
REQ-036 With GRAY_MON_DEC_EN, step gray 0001 then 0000 -> step_ok pulse; without it -> step_err pulse and fault=1.
